fft_stream_io: RTL and testbench
================================

// Module: fft_stream_io
// PURPOSE
//  Host-side counterpart of fft_control: streams N complex samples into the four radix-4
//  RAM banks, pulses oSTART, waits for the FFT core's iFFT_RDY, then reads the spectrum
//  back in digit-reversed (base-4) address order and emits it as a natural-order stream.
//  Sits between the sample source/sink and the bank RAMs that fft_control drives.
// PARAMETERS
//  N      256  FFT points; power of 4
//  A_BIT  8    log2(N); must be even
//  D_BIT  16   width of each real/imag component
// PORTS
//  iCLK        in   1          clock, all logic on rising edge
//  iRESET      in   1          asynchronous, active-low reset
//  iVALID      in   1          input sample valid
//  iDATA_RE    in   D_BIT      input sample, real
//  iDATA_IM    in   D_BIT      input sample, imag
//  oREADY      out  1          block accepts input sample this cycle
//  oWR_EN      out  4          one-hot bank write enable
//  oWR_ADDR    out  A_BIT-2    in-bank write address
//  oWR_DATA    out  2*D_BIT    {re,im} write data
//  oSTART      out  1          one-cycle start pulse to fft_control
//  iFFT_RDY    in   1          FFT complete (level or pulse)
//  oRD_ADDR    out  A_BIT-2    in-bank read address (same to all banks)
//  iRD_DATA    in   8*D_BIT    {bank3..bank0} x {re,im}; 1-cycle RAM read latency
//  oVALID      out  1          output bin valid
//  oDATA_RE    out  D_BIT      output bin, real
//  oDATA_IM    out  D_BIT      output bin, imag
//  oLAST       out  1          with oVALID on bin N-1
//  iREADY      in   1          sink accepts output bin
//  oBUSY       out  1          high in every state except LOAD
// BEHAVIOUR
//  Reset (async, iRESET=0): state LOAD, counters 0, output buffer empty; all outputs 0
//   except oREADY=1 after reset release. Reset mid-frame aborts it; no partial output.
//  Index map: sample n -> bank n[1:0], address n[A_BIT-1:2].
//  LOAD: oREADY=1; on iVALID&oREADY write combinationally: oWR_EN=1<<cnt[1:0],
//   oWR_ADDR=cnt[A_BIT-1:2], oWR_DATA={re,im}; cnt++. On write of sample N-1 -> START.
//  START: oREADY=0, oSTART=1 exactly one cycle -> HOLD.
//  HOLD: one cycle; iFFT_RDY ignored (masks stale RDY level) -> WAIT.
//  WAIT: until iFFT_RDY=1 -> UNLOAD, out counter k=0.
//  UNLOAD: bin k read from location r=digit_rev4(k) (reverse 2-bit digits of k).
//   Read issued (oRD_ADDR=r[A_BIT-1:2], bank r[1:0] registered) when
//   buffered + in-flight < 2 and k<N; k++ per issue. Next cycle iRD_DATA is muxed
//   by registered bank into a 2-entry skid buffer. Head drives oVALID/oDATA_*;
//   popped on oVALID&iREADY. oLAST=1 on bin N-1; its pop -> LOAD (cnt=0).
//  First oVALID 2 cycles after entering UNLOAD; with iREADY held 1, throughput 1 bin/cycle,
//   frame unload = N+2 cycles. oVALID/oDATA stable while iREADY=0 (no drop, no dup).
//  No write and read overlap: input is stalled (oREADY=0) from START to last pop.
//  iVALID while oREADY=0 is ignored (source must hold). No arithmetic on data.
// TESTING (N=16, A_BIT=4)
//  Reset, stream 16 samples re=n im=-n, iVALID=1 -> oWR_EN 0001,0010,0100,1000 repeating,
//   oWR_ADDR 0,0,0,0,1,...,3; oSTART one cycle 1 clk after 16th write; oREADY 0.
//  iFFT_RDY held 1 from before oSTART -> ignored in HOLD; UNLOAD entered from WAIT next cycle.
//  Bank model holds value=location; iREADY=1 -> bins read locations 0,4,8,12,1,5,...,15;
//   oLAST only on 16th; oREADY=1 cycle after last pop.
//  iREADY toggled 1/0 each cycle, plus 5-cycle stall -> 16 bins, correct order, no duplicates.
//  iRESET=0 during UNLOAD after 7 bins -> all outputs 0 immediately; new frame processes cleanly.
//  Back-to-back frames with iVALID gaps every 3rd cycle -> write count exactly 16 per frame.

Source files
------------

// File: rtl/fft_stream_io_if.sv
// Handshake and bank-RAM bundle between fft_stream_io and its source, sink, bank RAMs and fft_control.
// The master modport is the stream adapter's view; slave is the surrounding environment.
interface fft_stream_io_if #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
);
    logic                 iVALID;
    logic [D_BIT-1:0]     iDATA_RE;
    logic [D_BIT-1:0]     iDATA_IM;
    logic                 oREADY;
    logic [3:0]           oWR_EN;
    logic [A_BIT-3:0]     oWR_ADDR;
    logic [2*D_BIT-1:0]   oWR_DATA;
    logic                 oSTART;
    logic                 iFFT_RDY;
    logic [A_BIT-3:0]     oRD_ADDR;
    logic [8*D_BIT-1:0]   iRD_DATA;
    logic                 oVALID;
    logic [D_BIT-1:0]     oDATA_RE;
    logic [D_BIT-1:0]     oDATA_IM;
    logic                 oLAST;
    logic                 iREADY;
    logic                 oBUSY;

    modport master (
        input  iVALID, iDATA_RE, iDATA_IM, iFFT_RDY, iRD_DATA, iREADY,
        output oREADY, oWR_EN, oWR_ADDR, oWR_DATA, oSTART, oRD_ADDR,
               oVALID, oDATA_RE, oDATA_IM, oLAST, oBUSY
    );

    modport slave (
        output iVALID, iDATA_RE, iDATA_IM, iFFT_RDY, iRD_DATA, iREADY,
        input  oREADY, oWR_EN, oWR_ADDR, oWR_DATA, oSTART, oRD_ADDR,
               oVALID, oDATA_RE, oDATA_IM, oLAST, oBUSY
    );
endinterface

// File: rtl/fft_stream_io.sv
// Host-side stream adapter for fft_control: loads N samples into four radix-4 banks,
// starts the core, then returns the digit-reversed spectrum as a natural-order stream.
module fft_stream_io #(
    parameter int N     = 256,
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input logic             iCLK,
    input logic             iRESET,
    fft_stream_io_if.master bus
);
    localparam int W_BIT = 2 * D_BIT;

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_HOLD,
        S_WAIT,
        S_UNLOAD
    } state_t;

    state_t           state_q, state_d;
    logic [A_BIT-1:0] cnt_q, cnt_d;
    logic [A_BIT:0]   k_q, k_d;
    logic [A_BIT-1:0] out_cnt_q, out_cnt_d;
    logic             in_flight_q, in_flight_d;
    logic [1:0]       rd_bank_q, rd_bank_d;
    logic [W_BIT-1:0] buf_q [2];
    logic [W_BIT-1:0] buf_d [2];
    logic [1:0]       buf_cnt_q, buf_cnt_d;

    logic [A_BIT-1:0] rd_loc;
    logic [W_BIT-1:0] rd_word;
    logic [1:0]       occupancy;
    logic [1:0]       push_slot;
    logic             out_valid;
    logic             pop;
    logic             issue;

    function automatic logic [A_BIT-1:0] digit_rev4(input logic [A_BIT-1:0] v);
        logic [A_BIT-1:0] r;
        r = '0;
        for (int i = 0; i < A_BIT / 2; i++) begin
            r[2*i +: 2] = v[A_BIT-2-2*i +: 2];
        end
        return r;
    endfunction

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            k_q         <= '0;
            out_cnt_q   <= '0;
            in_flight_q <= 1'b0;
            rd_bank_q   <= '0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            buf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            out_cnt_q   <= out_cnt_d;
            in_flight_q <= in_flight_d;
            rd_bank_q   <= rd_bank_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
            buf_cnt_q   <= buf_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        out_cnt_d   = out_cnt_q;
        in_flight_d = 1'b0;
        rd_bank_d   = rd_bank_q;
        buf_d[0]    = buf_q[0];
        buf_d[1]    = buf_q[1];
        buf_cnt_d   = buf_cnt_q;

        bus.oREADY   = 1'b0;
        bus.oWR_EN   = '0;
        bus.oWR_ADDR = '0;
        bus.oWR_DATA = '0;
        bus.oSTART   = 1'b0;
        bus.oRD_ADDR = '0;
        bus.oVALID   = 1'b0;
        bus.oDATA_RE = '0;
        bus.oDATA_IM = '0;
        bus.oLAST    = 1'b0;
        bus.oBUSY    = (state_q != S_LOAD);

        rd_loc = digit_rev4(k_q[A_BIT-1:0]);
        case (rd_bank_q)
            2'd0:    rd_word = bus.iRD_DATA[0*W_BIT +: W_BIT];
            2'd1:    rd_word = bus.iRD_DATA[1*W_BIT +: W_BIT];
            2'd2:    rd_word = bus.iRD_DATA[2*W_BIT +: W_BIT];
            default: rd_word = bus.iRD_DATA[3*W_BIT +: W_BIT];
        endcase

        out_valid = (buf_cnt_q != 2'd0);
        pop       = out_valid && bus.iREADY;
        if (out_valid) begin
            bus.oVALID   = 1'b1;
            bus.oDATA_RE = buf_q[0][W_BIT-1:D_BIT];
            bus.oDATA_IM = buf_q[0][D_BIT-1:0];
            bus.oLAST    = (out_cnt_q == A_BIT'(N - 1));
        end

        // A slot freed by this cycle's pop may be refilled, which sustains one bin per cycle.
        occupancy = buf_cnt_q + {1'b0, in_flight_q} - {1'b0, pop};
        issue     = (state_q == S_UNLOAD) && (k_q < (A_BIT + 1)'(N)) && (occupancy < 2'd2);

        case (state_q)
            S_LOAD: begin
                bus.oREADY = 1'b1;
                if (bus.iVALID) begin
                    bus.oWR_EN   = 4'b0001 << cnt_q[1:0];
                    bus.oWR_ADDR = cnt_q[A_BIT-1:2];
                    bus.oWR_DATA = {bus.iDATA_RE, bus.iDATA_IM};
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == A_BIT'(N - 1)) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                bus.oSTART = 1'b1;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.iFFT_RDY) begin
                    state_d   = S_UNLOAD;
                    k_d       = '0;
                    out_cnt_d = '0;
                end
            end
            S_UNLOAD: begin
                if (issue) begin
                    bus.oRD_ADDR = rd_loc[A_BIT-1:2];
                    rd_bank_d    = rd_loc[1:0];
                    in_flight_d  = 1'b1;
                    k_d          = k_q + 1'b1;
                end
                if (pop && (out_cnt_q == A_BIT'(N - 1))) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        if (pop) begin
            buf_d[0]  = buf_q[1];
            out_cnt_d = out_cnt_q + 1'b1;
        end
        push_slot = buf_cnt_q - {1'b0, pop};
        if (in_flight_q) begin
            buf_d[push_slot[0]] = rd_word;
        end
        buf_cnt_d = buf_cnt_q - {1'b0, pop} + {1'b0, in_flight_q};

        // Every output reads low for as long as reset is held, including the ready flag.
        if (!iRESET) begin
            bus.oREADY   = 1'b0;
            bus.oWR_EN   = '0;
            bus.oWR_ADDR = '0;
            bus.oWR_DATA = '0;
            bus.oSTART   = 1'b0;
            bus.oRD_ADDR = '0;
            bus.oVALID   = 1'b0;
            bus.oDATA_RE = '0;
            bus.oDATA_IM = '0;
            bus.oLAST    = 1'b0;
            bus.oBUSY    = 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_stream_io.sv
// Bench for fft_stream_io at N=16: table-driven load vectors, a bank RAM model, and a
// digit-reversal reference that predicts every output bin from the samples sent in.
module tb_fft_stream_io;
    localparam int N     = 16;
    localparam int A_BIT = 4;
    localparam int D_BIT = 16;

    typedef struct packed {
        logic [D_BIT-1:0]   re;
        logic [D_BIT-1:0]   im;
        logic [3:0]         wr_en;
        logic [A_BIT-3:0]   wr_addr;
        logic [2*D_BIT-1:0] wr_data;
    } vec_t;

    logic iCLK = 1'b0;
    logic iRESET = 1'b1;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs [N];
    logic [2*D_BIT-1:0] mem [4][N/4];

    fft_stream_io_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

    fft_stream_io #(.N(N), .A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .bus    (bus)
    );

    always #5 iCLK = ~iCLK;

    // Four bank RAMs with a one-cycle registered read port.
    always @(posedge iCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.oWR_EN[b]) mem[b][bus.oWR_ADDR] <= bus.oWR_DATA;
            bus.iRD_DATA[b*2*D_BIT +: 2*D_BIT] <= mem[b][bus.oRD_ADDR];
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int digit_rev(input int k);
        int r = 0;
        int v = k;
        for (int d = 0; d < A_BIT / 2; d++) begin
            r = r * 4 + v % 4;
            v = v / 4;
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fill_vecs(input bit directed);
        for (int n = 0; n < N; n++) begin
            vecs[n].re      = directed ? 16'(n) : 16'($urandom);
            vecs[n].im      = directed ? 16'(-n) : ((16'($urandom) & 16'hFFF0) | 16'(n));
            vecs[n].wr_en   = 4'(1 << (n % 4));
            vecs[n].wr_addr = 2'(n / 4);
            vecs[n].wr_data = {vecs[n].re, vecs[n].im};
        end
    endtask

    task automatic apply_stimulus_load(input int gap_mode);
        int   n = 0;
        int   cyc = 0;
        int   writes = 0;
        logic v;
        while (n < N && cyc < 200) begin
            @(negedge iCLK);
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 != 2);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.iVALID   = v;
            bus.iDATA_RE = v ? vecs[n].re : 16'($urandom);
            bus.iDATA_IM = v ? vecs[n].im : 16'($urandom);
            bus.iREADY   = 1'($urandom_range(0, 1));
            #1;
            if (bus.oWR_EN != 4'b0) writes++;
            if (v && bus.oREADY) begin
                check_output("write", {bus.oREADY, bus.oWR_EN, bus.oWR_ADDR, bus.oWR_DATA},
                             {1'b1, vecs[n].wr_en, vecs[n].wr_addr, vecs[n].wr_data});
                n++;
            end else begin
                check_output("load_idle", {bus.oWR_EN, bus.oVALID, bus.oSTART}, '0);
            end
            cyc++;
        end
        check_output("write_count", writes, N);
    endtask

    task automatic apply_stimulus_unload(input int ready_mode, input bit rdy_level, input int rdy_at,
                                         input int abort_after, output int first, output int lastpop);
        int   k = 0;
        int   cyc = 0;
        int   loc;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [2*D_BIT-1:0] pd = '0;
        first   = -1;
        lastpop = -1;
        while (k < N && cyc < 300) begin
            @(negedge iCLK);
            bus.iFFT_RDY = rdy_level ? (cyc >= rdy_at) : (cyc == rdy_at);
            case (ready_mode)
                0:       bus.iREADY = 1'b1;
                1:       bus.iREADY = (cyc % 2 == 0);
                2:       bus.iREADY = (cyc >= 8 && cyc < 13) ? 1'b0 : (cyc % 2 == 0);
                default: bus.iREADY = ($urandom_range(0, 2) != 0);
            endcase
            bus.iVALID   = 1'($urandom_range(0, 1));
            bus.iDATA_RE = 16'($urandom);
            bus.iDATA_IM = 16'($urandom);
            #1;
            check_output("input_stalled", {bus.oREADY, bus.oWR_EN}, '0);
            if (pv && !pr) begin
                check_output("hold_stable", {bus.oVALID, bus.oDATA_RE, bus.oDATA_IM}, {1'b1, pd});
            end
            if (bus.oVALID && first < 0) first = cyc;
            if (bus.oVALID && bus.iREADY) begin
                loc = digit_rev(k);
                check_output("bin", {bus.oDATA_RE, bus.oDATA_IM, bus.oLAST},
                             {vecs[loc].re, vecs[loc].im, (k == N - 1)});
                k++;
                lastpop = cyc;
            end
            pv  = bus.oVALID;
            pr  = bus.iREADY;
            pd  = {bus.oDATA_RE, bus.oDATA_IM};
            cyc++;
            if (abort_after > 0 && k == abort_after) break;
        end
        if (abort_after == 0 && k < N) check_output("unload_timeout", k, N);
    endtask

    task automatic run_frame(input int gap_mode, input int ready_mode, input bit rdy_level,
                             input int rdy_at, input int abort_after);
        int first;
        int lastpop;
        bus.iFFT_RDY = rdy_level;
        apply_stimulus_load(gap_mode);
        @(negedge iCLK);
        bus.iVALID   = 1'b1;
        bus.iDATA_RE = 16'hDEAD;
        bus.iDATA_IM = 16'hBEEF;
        #1;
        check_output("start", {bus.oSTART, bus.oREADY, bus.oBUSY, bus.oWR_EN}, {1'b1, 1'b0, 1'b1, 4'b0});
        @(negedge iCLK);
        #1;
        check_output("hold", {bus.oSTART, bus.oREADY, bus.oBUSY, bus.oVALID, bus.oWR_EN},
                     {1'b0, 1'b0, 1'b1, 1'b0, 4'b0});
        apply_stimulus_unload(ready_mode, rdy_level, rdy_at, abort_after, first, lastpop);
        check_output("first_valid", first, rdy_at + 3);
        if (abort_after == 0) begin
            if (ready_mode == 0) check_output("throughput", lastpop - first, N - 1);
            @(negedge iCLK);
            bus.iVALID = 1'b0;
            bus.iREADY = 1'b0;
            #1;
            check_output("reload", {bus.oREADY, bus.oBUSY, bus.oVALID, bus.oSTART}, 4'b1000);
        end
        bus.iFFT_RDY = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check_output(name, {bus.oREADY, bus.oWR_EN, bus.oWR_ADDR, bus.oWR_DATA, bus.oSTART, bus.oRD_ADDR,
                            bus.oVALID, bus.oDATA_RE, bus.oDATA_IM, bus.oLAST, bus.oBUSY}, '0);
    endtask

    initial begin
        bus.iVALID   = 1'b0;
        bus.iDATA_RE = '0;
        bus.iDATA_IM = '0;
        bus.iFFT_RDY = 1'b0;
        bus.iREADY   = 1'b0;
        #2;
        iRESET = 1'b0;
        #1;
        check_all_zero("reset_outputs");
        bus.iVALID = 1'b1;
        repeat (3) @(negedge iCLK);
        #1;
        check_all_zero("reset_held");
        @(negedge iCLK);
        iRESET     = 1'b1;
        bus.iVALID = 1'b0;
        #1;
        check_output("reset_release", {bus.oREADY, bus.oBUSY, bus.oVALID, bus.oSTART, bus.oLAST}, 5'b10000);

        // Ramp frame with RDY already high before the start pulse; iREADY held high.
        fill_vecs(1'b1);
        run_frame(0, 0, 1'b1, 0, 0);

        // Alternating sink ready with a five-cycle stall, RDY as a late pulse.
        fill_vecs(1'b0);
        run_frame(0, 2, 1'b0, 2, 0);
        fill_vecs(1'b0);
        run_frame(0, 1, 1'b0, 0, 0);

        // Reset lands mid-unload after seven bins; everything must drop immediately.
        fill_vecs(1'b0);
        run_frame(0, 0, 1'b0, 1, 7);
        iRESET     = 1'b0;
        bus.iVALID = 1'b1;
        #1;
        check_all_zero("abort_outputs");
        repeat (2) @(negedge iCLK);
        iRESET     = 1'b1;
        bus.iVALID = 1'b0;
        #1;
        check_output("abort_release", {bus.oREADY, bus.oBUSY, bus.oVALID}, 3'b100);
        fill_vecs(1'b0);
        run_frame(2, 3, 1'b0, 1, 0);

        // Back-to-back frames with a source gap every third cycle.
        for (int f = 0; f < 2; f++) begin
            fill_vecs(1'b0);
            run_frame(1, 0, 1'b0, 0, 0);
        end

        // Fully randomised frames.
        for (int f = 0; f < 4; f++) begin
            fill_vecs(1'b0);
            run_frame(2, 3, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
